// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back cache controller between a CPU port, a cache-block RAM and a line-wide memory port.
// Ports: clk/rst_n (async active-low); cpu_* request/response; blk_* block RAM control, write data and stored
// tag/valid/dirty/line; mem_* line-wide memory request, write-back data, refill data and ack.
module cache_ctrl #(
   parameter int Tag_Width   = 18,
   parameter int Index_Width = 10,
   parameter int Line_Bits   = 128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cpu_req,
   input  logic                   cpu_wr,
   input  logic [31:0]            cpu_addr,
   input  logic [3:0]             cpu_be,
   input  logic [31:0]            cpu_wdata,
   output logic [31:0]            cpu_rdata,
   output logic                   cpu_ready,
   output logic                   cpu_err,
   output logic                   blk_en,
   output logic                   blk_wr,
   output logic [3:0]             blk_en_word,
   output logic [3:0]             blk_en_byte,
   output logic [Index_Width-1:0] blk_index,
   output logic [Tag_Width-1:0]   blk_tag_in,
   output logic                   blk_valid_new,
   output logic                   blk_dirty_new,
   output logic [Line_Bits-1:0]   blk_data_in,
   input  logic [Tag_Width-1:0]   blk_tag_out,
   input  logic                   blk_valid_out,
   input  logic                   blk_dirty_out,
   input  logic [Line_Bits-1:0]   blk_data_out,
   output logic                   mem_req,
   output logic                   mem_wr,
   output logic [31:0]            mem_addr,
   output logic [Line_Bits-1:0]   mem_wdata,
   input  logic [Line_Bits-1:0]   mem_rdata,
   input  logic                   mem_ack
);
   typedef enum logic [2:0] {IDLE, LOOKUP, WR_HIT, WBACK, REFILL, FILL, RESP} state_t;
   state_t                 r_state;
   logic                   r_wr;
   logic [31:2]            r_addr;
   logic [3:0]             r_be;
   logic [31:0]            r_wdata;
   logic [Tag_Width-1:0]   r_vtag;
   logic [Line_Bits-1:0]   r_vdata;
   logic [Line_Bits-1:0]   r_fill;
   logic [31:0]            r_cpu_rdata;
   logic                   r_cpu_ready;
   logic                   r_cpu_err;
   logic [Tag_Width-1:0]   w_tag;
   logic [Index_Width-1:0] w_index;
   logic [1:0]             w_word;
   logic                   w_hit;
   logic                   w_be_ok;
   logic                   w_acc;
   logic                   w_bw;
   logic [Line_Bits-1:0]   w_merged;
   logic                   w_unused;
   assign w_unused = ^cpu_addr[1:0];
   assign w_tag    = r_addr[31 -: Tag_Width];
   assign w_index  = r_addr[4 +: Index_Width];
   assign w_word   = r_addr[3:2];
   assign w_hit    = blk_valid_out && (blk_tag_out == w_tag);
   assign w_be_ok  = r_be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   // The RAM read is launched straight from the IDLE request so its data is ready in LOOKUP.
   assign w_acc    = rst_n && (r_state == IDLE) && cpu_req;
   assign w_bw     = (r_state == WR_HIT) || (r_state == FILL);
   // Refill line with the write's enabled bytes overlaid on the addressed word.
   always_comb begin
      w_merged = r_fill;
      for (int b = 0; b < 4; b++)
         if (r_wr && r_be[b]) w_merged[{w_word, 2'(b), 3'b000} +: 8] = r_wdata[8*b +: 8];
   end
   assign cpu_rdata     = r_cpu_rdata;
   assign cpu_ready     = r_cpu_ready;
   assign cpu_err       = r_cpu_err;
   assign blk_en        = w_acc || w_bw;
   assign blk_wr        = w_bw;
   assign blk_index     = w_acc ? cpu_addr[4 +: Index_Width] : w_index;
   assign blk_en_word   = (r_state == WR_HIT) ? 4'b0001 << w_word : (r_state == FILL) ? 4'hF : 4'h0;
   assign blk_en_byte   = (r_state == WR_HIT) ? r_be : (r_state == FILL) ? 4'hF : 4'h0;
   assign blk_tag_in    = w_bw ? w_tag : '0;
   assign blk_valid_new = w_bw;
   assign blk_dirty_new = (r_state == WR_HIT) || ((r_state == FILL) && r_wr);
   assign blk_data_in   = (r_state == WR_HIT) ? {(Line_Bits/32){r_wdata}} : (r_state == FILL) ? w_merged : '0;
   assign mem_req       = (r_state == WBACK) || (r_state == REFILL);
   assign mem_wr        = r_state == WBACK;
   assign mem_addr      = (r_state == WBACK) ? {r_vtag, w_index, 4'b0} : (r_state == REFILL) ? {w_tag, w_index, 4'b0} : '0;
   assign mem_wdata     = (r_state == WBACK) ? r_vdata : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_be        <= '0;
         r_wdata     <= '0;
         r_vtag      <= '0;
         r_vdata     <= '0;
         r_fill      <= '0;
         r_cpu_rdata <= '0;
         r_cpu_ready <= 1'b0;
         r_cpu_err   <= 1'b0;
      end else begin
         r_cpu_ready <= 1'b0;
         r_cpu_err   <= 1'b0;
         case (r_state)
            IDLE: if (cpu_req) begin
               r_wr    <= cpu_wr;
               r_addr  <= cpu_addr[31:2];
               r_be    <= cpu_be;
               r_wdata <= cpu_wdata;
               r_state <= LOOKUP;
            end
            LOOKUP: if (r_wr && !w_be_ok) begin
               r_cpu_ready <= 1'b1;
               r_cpu_err   <= 1'b1;
               r_state     <= IDLE;
            end else if (w_hit) begin
               r_cpu_ready <= 1'b1;
               if (r_wr) r_state <= WR_HIT;
               else begin
                  r_cpu_rdata <= blk_data_out[{w_word, 5'b0} +: 32];
                  r_state     <= IDLE;
               end
            end else if (blk_valid_out && blk_dirty_out) begin
               r_vtag  <= blk_tag_out;
               r_vdata <= blk_data_out;
               r_state <= WBACK;
            end else r_state <= REFILL;
            WR_HIT: r_state <= IDLE;
            WBACK: if (mem_ack) r_state <= REFILL;
            REFILL: if (mem_ack) begin
               r_fill  <= mem_rdata;
               r_state <= FILL;
            end
            FILL: begin
               r_cpu_ready <= 1'b1;
               r_cpu_rdata <= w_merged[{w_word, 5'b0} +: 32];
               r_state     <= RESP;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: table-driven, scoreboarded bench for cache_ctrl with block RAM and memory models.
module tb_cache_ctrl;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         cpu_req, cpu_wr;
   logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]   cpu_be;
   logic         cpu_ready, cpu_err;
   logic         blk_en, blk_wr, blk_valid_new, blk_dirty_new;
   logic [3:0]   blk_en_word, blk_en_byte;
   logic [9:0]   blk_index;
   logic [17:0]  blk_tag_in, blk_tag_out;
   logic [127:0] blk_data_in, blk_data_out;
   logic         blk_valid_out, blk_dirty_out;
   logic         mem_req, mem_wr, mem_ack;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .cpu_err(cpu_err), .blk_en(blk_en), .blk_wr(blk_wr), .blk_en_word(blk_en_word),
      .blk_en_byte(blk_en_byte), .blk_index(blk_index), .blk_tag_in(blk_tag_in),
      .blk_valid_new(blk_valid_new), .blk_dirty_new(blk_dirty_new), .blk_data_in(blk_data_in),
      .blk_tag_out(blk_tag_out), .blk_valid_out(blk_valid_out), .blk_dirty_out(blk_dirty_out),
      .blk_data_out(blk_data_out), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Memory model: every line reads back a pattern derived from its address.
   function automatic logic [31:0] gw(input logic [31:0] a, input int k);
      return a ^ (32'h1357_9BDF * 32'(k + 1));
   endfunction
   function automatic logic [127:0] gen_line(input logic [31:0] a);
      return {gw(a, 3), gw(a, 2), gw(a, 1), gw(a, 0)};
   endfunction
   int ack_wait = 0, mcnt = 0;
   logic [31:0]  wb_addr = '0, rf_addr = '0;
   logic [127:0] wb_data = '0;
   assign mem_rdata = gen_line(mem_addr);
   // ack arrives after ack_wait request cycles; ack_wait = 0 acks in the first request cycle
   assign mem_ack   = mem_req && (mcnt == ack_wait);
   always @(posedge clk) begin
      mcnt <= (!mem_req || mem_ack) ? 0 : mcnt + 1;
      if (mem_req && mem_ack && mem_wr) begin
         wb_addr <= mem_addr;
         wb_data <= mem_wdata;
      end
      if (mem_req && mem_ack && !mem_wr) rf_addr <= mem_addr;
   end

   // Block RAM model: one-cycle registered read, byte-masked write.
   localparam logic [127:0] PRE = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
   logic preload;
   logic [17:0]  m_tag [1024];
   logic         m_v [1024], m_d [1024];
   logic [127:0] m_dat [1024];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) begin
            m_tag[i] <= '0; m_v[i] <= 1'b0; m_d[i] <= 1'b0; m_dat[i] <= '0;
         end
         m_tag[5] <= 18'h00001; m_v[5] <= 1'b1; m_dat[5] <= PRE;
         blk_tag_out <= '0; blk_valid_out <= 1'b0; blk_dirty_out <= 1'b0; blk_data_out <= '0;
      end else if (blk_en) begin
         if (blk_wr) begin
            for (int w = 0; w < 4; w++)
               for (int b = 0; b < 4; b++)
                  if (blk_en_word[w] && blk_en_byte[b]) m_dat[blk_index][w*32+b*8 +: 8] <= blk_data_in[w*32+b*8 +: 8];
            m_tag[blk_index] <= blk_tag_in;
            m_v[blk_index]   <= blk_valid_new;
            m_d[blk_index]   <= blk_dirty_new;
         end else begin
            blk_tag_out   <= m_tag[blk_index];
            blk_valid_out <= m_v[blk_index];
            blk_dirty_out <= m_d[blk_index];
            blk_data_out  <= m_dat[blk_index];
         end
      end
   end

   // Scoreboard and activity monitor, sampled on the falling edge.
   typedef struct {bit cd; logic [31:0] rd; logic err;} exp_t;
   exp_t sb[$];
   int ready_cnt = 0, err_cnt = 0, bw_cnt = 0, mem_cnt = 0;
   logic [3:0]   lw_word, lw_byte;
   logic         lw_dirty, lw_valid;
   logic [17:0]  lw_tag;
   logic [127:0] lw_data;
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req) mem_cnt++;
         if (cpu_err) err_cnt++;
         if (blk_en && blk_wr) begin
            bw_cnt++;
            lw_word = blk_en_word; lw_byte = blk_en_byte; lw_dirty = blk_dirty_new;
            lw_valid = blk_valid_new; lw_tag = blk_tag_in; lw_data = blk_data_in;
         end
         if (cpu_ready) begin
            ready_cnt++;
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_ready: cpu_ready got 1 with no request outstanding, expected 0");
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.cd) chk("rdata", cpu_rdata, e.rd);
               chk("err", cpu_err, e.err);
            end
         end
      end
   end

   typedef struct {
      bit wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int ack;
      bit cd; logic [31:0] rd; bit err; int lat; int mem; int bw;
   } txn_t;
   txn_t tv[9];

   task automatic run(input string nm, input txn_t t);
      int lat, r0, m0, b0, e0;
      bit done;
      exp_t e;
      r0 = ready_cnt; m0 = mem_cnt; b0 = bw_cnt; e0 = err_cnt;
      ack_wait = t.ack;
      e.cd = t.cd; e.rd = t.rd; e.err = t.err;
      sb.push_back(e);
      cpu_req = 1'b1; cpu_wr = t.wr; cpu_addr = t.addr; cpu_be = t.be; cpu_wdata = t.wdata;
      @(posedge clk);
      #1;
      cpu_req = 1'b0; cpu_wr = 1'($urandom); cpu_addr = $urandom; cpu_be = 4'($urandom); cpu_wdata = $urandom;
      lat = 0; done = 1'b0;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
         done = cpu_ready;
      end
      @(negedge clk);
      #1;
      chk({nm, "_latency"}, 128'(lat), 128'(t.lat));
      chk({nm, "_ready_pulses"}, 128'(ready_cnt - r0), 128'd1);
      chk({nm, "_mem_req_cycles"}, 128'(mem_cnt - m0), 128'(t.mem));
      chk({nm, "_blk_writes"}, 128'(bw_cnt - b0), 128'(t.bw));
      chk({nm, "_err_pulses"}, 128'(err_cnt - e0), 128'(t.err));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ctl_outs"}, {cpu_rdata, cpu_ready, cpu_err, blk_en, blk_wr, blk_en_word, blk_en_byte, blk_index,
                              blk_tag_in, blk_valid_new, blk_dirty_new, mem_req, mem_wr, mem_addr}, '0);
      chk({nm, "_blk_data_in"}, blk_data_in, '0);
      chk({nm, "_mem_wdata"}, mem_wdata, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m5;
      int r0, b0, m0;
      m5 = (gw(32'h0000C070, 1) & 32'hFFFF0000) | 32'h00005678;
      //            wr  addr          be     wdata         ack cd  rd                                               err lat mem bw
      tv[0] = '{1'b0, 32'h00004058, 4'h0, 32'h0,        0, 1'b1, 32'hDEADBEEF,                                     1'b0, 2, 0, 0};
      tv[1] = '{1'b1, 32'h00004058, 4'h4, 32'h00AB0000, 0, 1'b0, 32'h0,                                            1'b0, 2, 0, 1};
      tv[2] = '{1'b0, 32'h00004058, 4'h0, 32'h0,        0, 1'b1, 32'hDEABBEEF,                                     1'b0, 2, 0, 0};
      tv[3] = '{1'b0, 32'h00008058, 4'h0, 32'h0,        0, 1'b1, gw(32'h00008050, 2),                              1'b0, 5, 2, 1};
      tv[4] = '{1'b1, 32'h0000C074, 4'h3, 32'h12345678, 5, 1'b1, m5,                                               1'b0, 9, 6, 1};
      tv[5] = '{1'b1, 32'h00004058, 4'h6, 32'hFFFFFFFF, 0, 1'b0, 32'h0,                                            1'b1, 2, 0, 0};
      tv[6] = '{1'b0, 32'h0000C074, 4'h6, 32'h0,        0, 1'b1, m5,                                               1'b0, 2, 0, 0};
      tv[7] = '{1'b1, 32'h0000C07C, 4'hC, 32'hCAFE0000, 0, 1'b0, 32'h0,                                            1'b0, 2, 0, 1};
      tv[8] = '{1'b0, 32'h0000C07C, 4'h0, 32'h0,        0, 1'b1, (gw(32'h0000C070, 3) & 32'h0000FFFF) | 32'hCAFE0000, 1'b0, 2, 0, 0};
      rst_n = 1'b0; preload = 1'b1;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      preload = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         run($sformatf("t%0d", i), tv[i]);
         if (i == 1) begin
            chk("t1_en_word", lw_word, 4'b0100);
            chk("t1_en_byte", lw_byte, 4'b0100);
            chk("t1_dirty_new", lw_dirty, 1'b1);
            chk("t1_tag_in", lw_tag, 18'h00001);
            chk("t1_data_in", lw_data, {4{32'h00AB0000}});
         end
         if (i == 3) begin
            chk("t3_wback_addr", wb_addr, 32'h00004050);
            chk("t3_wback_data", wb_data, {32'h44444444, 32'hDEABBEEF, 32'h22222222, 32'h11111111});
            chk("t3_refill_addr", rf_addr, 32'h00008050);
            chk("t3_fill_dirty", lw_dirty, 1'b0);
            chk("t3_fill_valid", lw_valid, 1'b1);
            chk("t3_fill_tag", lw_tag, 18'h00002);
            chk("t3_fill_data", lw_data, gen_line(32'h00008050));
         end
         if (i == 4) begin
            chk("t4_refill_addr", rf_addr, 32'h0000C070);
            chk("t4_fill_masks", {lw_word, lw_byte}, 8'hFF);
            chk("t4_fill_dirty", lw_dirty, 1'b1);
            chk("t4_fill_data", lw_data, {gw(32'h0000C070, 3), gw(32'h0000C070, 2), m5, gw(32'h0000C070, 0)});
         end
      end
      // Abort a refill with a one-cycle reset, then check nothing leaks out of the dead request.
      ack_wait = 20;
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h00010090; cpu_be = 4'h0;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
      chk("rst_reached_refill", mem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      r0 = ready_cnt; b0 = bw_cnt; m0 = mem_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("rst_no_ready", 128'(ready_cnt - r0), 128'd0);
      chk("rst_no_blk_write", 128'(bw_cnt - b0), 128'd0);
      chk("rst_no_mem_req", 128'(mem_cnt - m0), 128'd0);
      run("t9", '{1'b0, 32'h00010090, 4'h0, 32'h0, 0, 1'b1, gw(32'h00010090, 0), 1'b0, 4, 1, 1});
      chk("t9_refill_addr", rf_addr, 32'h00010090);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- Tag_Width, 18, tag bits.
- Index_Width, 10, line index bits.
- Line_Bits, 128, line width; 4 words of 32 bits.
REQ-002 Address split: cpu_addr[31:14] tag, [13:4] index, [3:2] word, [1:0] byte; the controller ignores [1:0].
REQ-003 Ports: one clock; reset is asynchronous and active-low. Ports, one per line (name, direction, width, meaning):
- clk in 1: clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- cpu_req in 1: CPU request.
- cpu_wr in 1: 1 = write.
- cpu_addr in 32: byte address.
- cpu_be in 4: byte enables.
- cpu_wdata in 32: write data.
- cpu_rdata out 32: read data.
- cpu_ready out 1: one-cycle completion pulse.
- cpu_err out 1: illegal-enable pulse.
- blk_en out 1: cache-block RAM enable.
- blk_wr out 1: cache-block write.
- blk_en_word out 4: word select.
- blk_en_byte out 4: byte select.
- blk_index out 10: line index.
- blk_tag_in out 18: tag to write.
- blk_valid_new out 1: valid flag to write.
- blk_dirty_new out 1: dirty flag to write.
- blk_data_in out 128: line data to write.
- blk_tag_out in 18: stored tag.
- blk_valid_out in 1: stored valid flag.
- blk_dirty_out in 1: stored dirty flag.
- blk_data_out in 128: stored line data.
- mem_req out 1: memory request.
- mem_wr out 1: memory write.
- mem_addr out 32: line-aligned address.
- mem_wdata out 128: write-back line.
- mem_rdata in 128: refill line.
- mem_ack in 1: memory completion.

Function
REQ-004 The FSM shall have states IDLE, LOOKUP, WR_HIT, WBACK, REFILL, FILL, RESP. All outputs are registered or decoded from the state plus latched request registers.
REQ-005 IDLE, cpu_req=1: latch wr/addr/be/wdata; drive blk_en=1, blk_wr=0, blk_index=addr index; next LOOKUP. The CPU may change its inputs afterwards.
REQ-006 The block RAM read latency shall be 1 cycle; tag, valid, dirty and data are sampled in LOOKUP.
REQ-007 Hit = blk_valid_out && (blk_tag_out == latched tag).
REQ-008 Read hit: in LOOKUP, pulse cpu_ready=1 with cpu_rdata = blk_data_out word selected by addr[3:2] (word 0 = bits 31:0); next IDLE. Total latency is 2 cycles.
REQ-009 Write hit: go to WR_HIT. WR_HIT drives, for one cycle:
- blk_en=1, blk_wr=1.
- blk_en_word = one-hot(addr[3:2]); blk_en_byte = be.
- blk_data_in = wdata replicated 4 times.
- blk_tag_in = tag, valid_new=1, dirty_new=1.
Pulse cpu_ready in the same cycle; next IDLE.
REQ-010 Legal cpu_be values on a write: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other value: pulse cpu_ready and cpu_err in LOOKUP, perform no RAM or memory write, go to IDLE. Reads ignore be.
REQ-011 Miss with valid=1 and dirty=1: capture blk_data_out and blk_tag_out into a victim register; go to WBACK.
REQ-012 Any other miss: go to REFILL.
REQ-013 WBACK: mem_req=1, mem_wr=1, mem_addr = {victim tag, index, 4'b0}, mem_wdata = victim line. Hold until mem_ack=1; then go to REFILL.
REQ-014 REFILL: mem_req=1, mem_wr=0, mem_addr = {tag, index, 4'b0}. On mem_ack=1, capture mem_rdata into the fill buffer; go to FILL.
REQ-015 mem_ack is legal in the first request cycle (minimum 1 cycle per transfer). mem_ack sampled while mem_req=0 shall be ignored.
REQ-016 FILL drives, for one cycle:
- blk_en=1, blk_wr=1, blk_en_word=1111, blk_en_byte=1111.
- blk_tag_in = tag, valid_new=1, dirty_new = latched wr.
- blk_data_in = fill buffer; on a write, the be-selected bytes of the addressed word are replaced by wdata.
Next RESP.
REQ-017 RESP: pulse cpu_ready; cpu_rdata = addressed word of the merged line (reads and writes alike); next IDLE.
REQ-018 cpu_req is ignored in every state except IDLE. A new request is accepted in the cycle after cpu_ready.
REQ-019 blk_en=0 and mem_req=0 in all states and cycles not listed above.
REQ-020 cpu_rdata shall hold its last value when cpu_ready=0.

Reset
REQ-021 rst_n=0 forces, asynchronously: state IDLE and every output 0 (cpu_rdata, cpu_ready, cpu_err, blk_*, mem_*). Latched request, victim and fill registers are cleared to 0.
REQ-022 Reset asserted mid-transaction aborts it with no further RAM write and no memory request; no cpu_ready is issued for the aborted request.
REQ-023 The first request is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-024 Read hit: line index 0x005 preloaded with tag 0x00001, valid=1, word 2 = 0xDEADBEEF; read of 0x00004058 -> cpu_ready 2 cycles after acceptance, cpu_rdata=0xDEADBEEF, mem_req stays 0.
REQ-025 Write hit, byte: be=0100, wdata=0x00AB0000 to the same line -> one WR_HIT cycle with en_word=0100, en_byte=0100, dirty_new=1; a re-read returns 0xDEABBEEF.
REQ-026 Dirty miss: that index now dirty; read of tag 0x00002, same index -> write-back to mem_addr=0x00004050 carrying the old line, then refill from 0x00008050; FILL writes dirty_new=0; RESP returns the refill word.
REQ-027 Clean write miss: mem_ack delayed 5 cycles -> mem_req held all 5 cycles; FILL line merges wdata with dirty_new=1; exactly one cpu_ready pulse.
REQ-028 Illegal enable: write with be=0110 -> cpu_err=1 and cpu_ready=1 in the same cycle; no blk_wr and no mem_req.
REQ-029 Reset in REFILL while mem_req=1: rst_n low for 1 cycle -> all outputs 0 immediately; the next request is serviced normally.
